seven_seg_rx: RTL and testbench
===============================

Name: seven_seg_rx

Overview:
Receive-side counterpart of the multiplexed 7-segment display driver. Monitors the scanned digit_sel/seg_out bus of a 4-digit common-anode display and decodes each segment pattern back to a BCD digit. Assembles a full 4-digit frame and converts it to a 14-bit binary value (0..9999). Used for loopback self-check of the display path and for board-level capture of display traffic.

Parameters:
STABLE_CYC, 4, cycles the synchronised (digit_sel, seg_out) pair must stay unchanged before a digit is accepted; legal range 2..255
SEL_ACTIVE_LOW, 1, 1 = digit_sel is active-low one-hot; 0 = active-high one-hot

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
digit_sel  input  4  digit enable, one-hot; bit0 = ones, bit1 = tens, bit2 = hundreds, bit3 = thousands
seg_out  input  7  segments {a,b,c,d,e,f,g}, MSB = a, active-low (0 = lit)
dout  output  14  last decoded binary value
dout_valid  output  1  one-cycle pulse; dout updated in the same cycle
seg_err  output  1  one-cycle pulse on capture of an undecodable pattern

Behaviour:
- Reset: all registers cleared; dout = 0, dout_valid = 0, seg_err = 0, FSM = IDLE, seen = 0, stability counter = 0.
- Input path: digit_sel and seg_out each pass through a 2-flop synchroniser. All further logic uses the synchronised values.
- Stability filter: an 8-bit counter clears whenever the synchronised pair differs from the previous cycle, otherwise it increments and saturates.
  - When the counter reaches STABLE_CYC-1, a single capture strobe fires. There is no further strobe until the pair changes.
  - No strobe fires if digit_sel is not exactly one-hot in the configured polarity. This covers all-off and multi-hot.
- Decode table (active-low):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0001100=9.
  - Any other pattern, including blank 1111111, is invalid. On an invalid capture, seg_err pulses in the cycle after the strobe.
- Frame assembly:
  - Registers: bcd[3:0][3:0], seen[3:0], bad.
  - On capture for slot k: write bcd[k], set seen[k]; an invalid pattern sets bad.
  - If seen[k] was already set (repeat before frame complete), resync: seen becomes only bit k, and bad is recomputed from this capture alone.
  - When seen == 4'b1111, the frame is complete.
- Conversion FSM: IDLE -> LOAD -> CONV -> DONE -> IDLE.
  - LOAD: 1 cycle. Copies bcd into shadow registers and clears seen and bad, so new captures proceed during conversion. A frame with bad = 1 does not leave IDLE; it only clears seen and bad.
  - CONV: 4 cycles, from the thousands digit down to ones: acc <= (acc<<3) + (acc<<1) + digit. acc is 14 bits; max 9999 never overflows.
  - DONE: dout <= acc, dout_valid = 1 for exactly one cycle.
- Latency: dout_valid asserts exactly 6 cycles after the capture strobe of the completing digit (LOAD at +1, CONV at +2..+5, DONE at +6).
- Simultaneous events: a frame completing while the FSM is not IDLE is held (seen stays 1111) until the FSM returns to IDLE, then enters LOAD. Captures for an already-complete held frame are handled as repeats (resync).
- dout holds its value between dout_valid pulses.
- Reset mid-operation aborts any conversion; no dout_valid is produced for the aborted frame.

Optional Feature:
SEVEN_SEG_RX_BCD_EN:
- Defined: adds output port dout_bcd[15:0] = {thousands, hundreds, tens, ones}, loaded from the shadow registers in DONE together with dout. Reset value 0.
- Undefined: the port and its registers are absent; all other behaviour is identical.

Test Plan:
- Scan 1234 (ones->tens->hundreds->thousands, 16 cycles per digit, repeated) -> dout_valid pulse with dout = 1234, seg_err never high, pulse repeats once per frame.
- Scan 9999, then 0000 -> dout = 9999 (14'h270F), then dout = 0; exactly 6 cycles from the thousands-digit strobe to each pulse.
- Hold the tens digit for only 2 cycles inside an otherwise valid scan of 5678 (STABLE_CYC = 4) -> tens ignored, no pulse for that partial frame; next full scan gives 5678.
- Drive 1111111 on the tens slot of one frame -> seg_err pulses once, no dout_valid for that frame, dout unchanged; following clean 4321 frame gives dout = 4321.
- Order ones, tens, ones, tens, hundreds, thousands for value 0042 -> resync on the repeated ones, a single pulse with dout = 42.
- Assert rst during CONV of frame 8765 -> dout = 0 and dout_valid stays low; after release, a full new scan of 8765 yields dout = 8765.

Source files
------------

// File: rtl/seven_seg_rx.sv
// seven_seg_rx: decodes a scanned 4-digit common-anode 7-segment bus back to BCD and binary (0..9999).
// Optional: define SEVEN_SEG_RX_BCD_EN to add the dout_bcd output.
module seven_seg_rx #(
   parameter int STABLE_CYC     = 4,
   parameter bit SEL_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  digit_sel,
   input  logic [6:0]  seg_out,
   output logic [13:0] dout,
   output logic        dout_valid,
`ifdef SEVEN_SEG_RX_BCD_EN
   output logic [15:0] dout_bcd,
`endif
   output logic        seg_err
);

   typedef enum logic [1:0] {IDLE, LOAD, CONV, DONE} state_t;

   logic [3:0]       sel_s1, sel_s2, sel_p, sel_eff, slot_bit;
   logic [6:0]       seg_s1, seg_s2, seg_p;
   logic [7:0]       cnt;
   logic             changed, one_hot, strobe;
   logic [1:0]       slot;
   logic [3:0]       dig;
   logic             dig_ok;
   logic [3:0][3:0]  bcd, sh;
   logic [3:0]       seen, seen_c, seen_d;
   logic             bad, bad_c, bad_d, complete;
   state_t           state, state_d;
   logic [1:0]       idx;
   logic [13:0]      acc, acc_d;

   assign changed    = {sel_s2, seg_s2} != {sel_p, seg_p};
   assign sel_eff    = SEL_ACTIVE_LOW ? ~sel_s2 : sel_s2;
   assign one_hot    = $onehot(sel_eff);
   assign strobe     = !changed && one_hot && (cnt == 8'(STABLE_CYC - 1));
   assign slot       = {sel_eff[3] | sel_eff[2], sel_eff[3] | sel_eff[1]};
   assign slot_bit   = 4'b0001 << slot;
   assign acc_d      = (acc << 3) + (acc << 1) + 14'(sh[idx]);
   assign dout_valid = state == DONE;

   // two-flop synchronisers plus the previous-cycle copy used for change detection
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_s1 <= '0;
         sel_s2 <= '0;
         sel_p  <= '0;
         seg_s1 <= '0;
         seg_s2 <= '0;
         seg_p  <= '0;
      end else begin
         sel_s1 <= digit_sel;
         sel_s2 <= sel_s1;
         sel_p  <= sel_s2;
         seg_s1 <= seg_out;
         seg_s2 <= seg_s1;
         seg_p  <= seg_s2;
      end
   end

   // stability counter: restarts on any change of the pair, saturates at 255
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else
         cnt <= changed ? 8'd0 : (cnt == 8'hFF ? cnt : cnt + 8'd1);
   end

   // active-low segment pattern to BCD digit; anything off-table is invalid
   always_comb begin
      dig    = '0;
      dig_ok = 1'b1;
      case (seg_s2)
         7'b0000001: dig = 4'd0;
         7'b1001111: dig = 4'd1;
         7'b0010010: dig = 4'd2;
         7'b0000110: dig = 4'd3;
         7'b1001100: dig = 4'd4;
         7'b0100100: dig = 4'd5;
         7'b0100000: dig = 4'd6;
         7'b0001111: dig = 4'd7;
         7'b0000000: dig = 4'd8;
         7'b0001100: dig = 4'd9;
         default:    dig_ok = 1'b0;
      endcase
   end

   // frame assembly: a repeat of an already-seen slot restarts the frame from that slot
   always_comb begin
      seen_c   = strobe ? (seen[slot] ? slot_bit : seen | slot_bit) : seen;
      bad_c    = strobe ? (seen[slot] ? !dig_ok : bad | !dig_ok) : bad;
      complete = seen_c == 4'hF;
      seen_d   = seen_c;
      bad_d    = bad_c;
      if (state == LOAD) begin
         seen_d = strobe ? slot_bit : 4'h0;
         bad_d  = strobe && !dig_ok;
      end else if (state == IDLE && complete && bad_c) begin
         seen_d = 4'h0;
         bad_d  = 1'b0;
      end
   end

   // capture registers and the invalid-pattern pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bcd     <= '0;
         seen    <= '0;
         bad     <= 1'b0;
         seg_err <= 1'b0;
      end else begin
         if (strobe)
            bcd[slot] <= dig;
         seen    <= seen_d;
         bad     <= bad_d;
         seg_err <= strobe && !dig_ok;
      end
   end

   // conversion FSM next state; a complete frame waits in seen until IDLE
   always_comb begin
      state_d = state;
      case (state)
         IDLE:    state_d = (complete && !bad_c) ? LOAD : IDLE;
         LOAD:    state_d = CONV;
         CONV:    state_d = (idx == 2'd0) ? DONE : CONV;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= IDLE;
      else
         state <= state_d;
   end

   // shadow copy and multiply-by-ten accumulation, thousands first; dout lands as DONE begins
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sh   <= '0;
         acc  <= '0;
         idx  <= '0;
         dout <= '0;
`ifdef SEVEN_SEG_RX_BCD_EN
         dout_bcd <= '0;
`endif
      end else if (state == LOAD) begin
         sh  <= bcd;
         acc <= '0;
         idx <= 2'd3;
      end else if (state == CONV) begin
         acc <= acc_d;
         idx <= idx - 2'd1;
         if (idx == 2'd0) begin
            dout <= acc_d;
`ifdef SEVEN_SEG_RX_BCD_EN
            dout_bcd <= sh;
`endif
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_rx.sv
// tb_seven_seg_rx: directed scans of the display bus with hand-computed decoded values.
module tb_seven_seg_rx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  digit_sel = 4'hF;
   logic [6:0]  seg_out = 7'h7F;
   logic [13:0] dout;
   logic        dout_valid;
   logic        seg_err;
`ifdef SEVEN_SEG_RX_BCD_EN
   logic [15:0] dout_bcd;
`endif

   int          n_asrt = 0;
   int          n_fail = 0;
   int          pcyc = 0;
   int          vcnt = 0;
   int          ecnt = 0;
   int          vlast_cyc = 0;
   int          t_drive = 0;
   int          t_th = 0;
   logic [13:0] vlast_val = '0;
   logic [6:0]  pats [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                              7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0001100};

   seven_seg_rx dut (
      .clk(clk),
      .rst(rst),
      .digit_sel(digit_sel),
      .seg_out(seg_out),
      .dout(dout),
      .dout_valid(dout_valid),
`ifdef SEVEN_SEG_RX_BCD_EN
      .dout_bcd(dout_bcd),
`endif
      .seg_err(seg_err)
   );

   always #5 clk = ~clk;

   // posedge counter used as the time reference for latency checks
   always @(posedge clk) pcyc <= pcyc + 1;

   // pulse monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (dout_valid) begin
         vcnt++;
         vlast_val = dout;
         vlast_cyc = pcyc;
      end
      if (seg_err) ecnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // present one digit (active-low select) for n cycles, starting at a falling edge
   task automatic show(input int k, input logic [6:0] pat, input int n);
      @(negedge clk);
      digit_sel = ~(4'b0001 << k);
      seg_out   = pat;
      t_drive   = pcyc;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic frame(input int d3, input int d2, input int d1, input int d0);
      show(0, pats[d0], 16);
      show(1, pats[d1], 16);
      show(2, pats[d2], 16);
      show(3, pats[d3], 16);
      t_th = t_drive;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_valid", 32'(dout_valid), 0);
      chk("rst_err", 32'(seg_err), 0);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      // strobe lands 6 cycles after a drive, dout_valid 6 cycles after that
      frame(1, 2, 3, 4);
      chk("f1234_cnt", vcnt, 1);
      chk("f1234_val", 32'(vlast_val), 1234);
      chk("f1234_lat", vlast_cyc - t_th, 12);
      frame(1, 2, 3, 4);
      chk("f1234b_cnt", vcnt, 2);
      chk("f1234b_val", 32'(vlast_val), 1234);
      frame(9, 9, 9, 9);
      chk("f9999_cnt", vcnt, 3);
      chk("f9999_val", 32'(vlast_val), 32'h270F);
      chk("f9999_lat", vlast_cyc - t_th, 12);
      frame(0, 0, 0, 0);
      chk("f0000_cnt", vcnt, 4);
      chk("f0000_val", 32'(vlast_val), 0);
      chk("f0000_lat", vlast_cyc - t_th, 12);
      // tens held too briefly to be accepted
      show(0, pats[8], 16);
      show(1, pats[7], 2);
      show(2, pats[6], 16);
      show(3, pats[5], 16);
      repeat (10) @(negedge clk);
      chk("glitch_cnt", vcnt, 4);
      chk("glitch_dout", 32'(dout), 0);
      frame(5, 6, 7, 8);
      chk("f5678_cnt", vcnt, 5);
      chk("f5678_val", 32'(vlast_val), 5678);
      // blank pattern on the tens slot
      show(0, pats[1], 16);
      show(1, 7'h7F, 16);
      show(2, pats[3], 16);
      show(3, pats[4], 16);
      repeat (10) @(negedge clk);
      chk("bad_err", ecnt, 1);
      chk("bad_cnt", vcnt, 5);
      chk("bad_dout", 32'(dout), 5678);
      frame(4, 3, 2, 1);
      chk("f4321_cnt", vcnt, 6);
      chk("f4321_val", 32'(vlast_val), 4321);
      chk("f4321_err", ecnt, 1);
      // repeated ones digit restarts the frame
      show(0, pats[2], 16);
      show(1, pats[4], 16);
      show(0, pats[2], 16);
      show(1, pats[4], 16);
      show(2, pats[0], 16);
      show(3, pats[0], 16);
      chk("f0042_cnt", vcnt, 7);
      chk("f0042_val", 32'(vlast_val), 42);
      // reset lands in the middle of the conversion of 8765
      show(0, pats[5], 16);
      show(1, pats[6], 16);
      show(2, pats[7], 16);
      show(3, pats[8], 10);
      rst = 1'b0;
      #1;
      chk("abort_dout", 32'(dout), 0);
      chk("abort_valid", 32'(dout_valid), 0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (20) @(negedge clk);
      chk("abort_cnt", vcnt, 7);
      chk("abort_dout2", 32'(dout), 0);
      frame(8, 7, 6, 5);
      chk("f8765_cnt", vcnt, 8);
      chk("f8765_val", 32'(vlast_val), 8765);
      chk("final_err", ecnt, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
